// File: rtl/inference_pkg.sv
// Shared definitions for the inference sequencer: FSM state encoding,
// class width and the default layer watchdog limit.
package inference_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    L1_WAIT = 2'd1,
    L2_WAIT = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  localparam int unsigned CLASS_W                = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;
  // Wide enough for the largest legal timeout (65535).
  localparam int unsigned WD_CNT_W               = 16;

  // True for the two states that wait on a layer's done pulse.
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == L1_WAIT) || (s == L2_WAIT);
  endfunction

endpackage

// File: rtl/inference_sequencer_watchdog.sv
// seq_watchdog: cycle counter for one layer wait state. It is cleared on
// entry to a wait state, counts while enabled, and raises expire during the
// last allowed cycle (the TIMEOUT_CYCLES-th cycle spent waiting).
// Only instantiated when INFERENCE_SEQ_WATCHDOG_EN is defined.
module seq_watchdog
  import inference_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WD_CNT_W-1:0] LIMIT   = WD_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_CNT_W-1:0] CNT_ONE = {{(WD_CNT_W-1){1'b0}}, 1'b1};

  logic [WD_CNT_W-1:0] cnt_q;
  logic [WD_CNT_W-1:0] cnt_d;

  // Next count: restart on entry, advance while waiting, hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {WD_CNT_W{1'b0}};
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WD_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on registered state, so it cannot loop back through clear.
  assign expire = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: sequences image loader -> Layer 1 -> Layer 2, registers
// the classified digit, queues one image that arrives mid-inference and counts
// dropped images. Defining INFERENCE_SEQ_WATCHDOG_EN adds a per-wait-state
// watchdog that aborts a layer which never signals done.
// Every output is driven straight from a flop.
module inference_sequencer
  import inference_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned DROP_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               img_ready,
  output logic               l1_start,
  input  logic               l1_done,
  output logic               l2_start,
  input  logic               l2_done,
  input  logic [CLASS_W-1:0] l2_class,
  output logic [CLASS_W-1:0] result,
  output logic               result_valid,
  output logic               busy,
  output logic               pending,
  output logic               overrun,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               error
);

  // DROP_W is expected to be at least 2.
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  seq_state_e         state_q, state_d;
  logic               l1_start_q, l1_start_d;
  logic               l2_start_q, l2_start_d;
  logic [CLASS_W-1:0] result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               busy_q, busy_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               error_q, error_d;
  logic               wd_expire;

`ifdef INFERENCE_SEQ_WATCHDOG_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_enable = is_wait_state(state_q);
  assign wd_clear  = (state_d != state_q) && is_wait_state(state_d);

  seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_seq_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // Next state, queue bookkeeping and the registered values of every output.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    pending_d  = pending_q;
    drop_cnt_d = drop_cnt_q;
    overrun_d  = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // A fresh pulse and a queued image both refer to the same x buffer.
        if (img_ready || pending_q) begin
          state_d   = L1_WAIT;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      L1_WAIT: begin
        // A done pulse wins over a simultaneous timeout; l2_done is ignored.
        if (l1_done) begin
          state_d = L2_WAIT;
        end else if (wd_expire) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          state_d = L1_WAIT;
        end
      end
      L2_WAIT: begin
        if (l2_done) begin
          state_d  = DONE;
          result_d = l2_class;
        end else if (wd_expire) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          state_d = L2_WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Images arriving outside IDLE: queue one, drop (and count) the rest.
    if (img_ready && (state_q != IDLE)) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
        if (drop_cnt_q != DROP_MAX) begin
          drop_cnt_d = drop_cnt_q + DROP_ONE;
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
      end
    end else begin
      overrun_d = 1'b0;
    end

    // Pulses fire in the first cycle of the state they announce.
    l1_start_d     = (state_q == IDLE)    && (state_d == L1_WAIT);
    l2_start_d     = (state_q == L1_WAIT) && (state_d == L2_WAIT);
    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      l1_start_q     <= 1'b0;
      l2_start_q     <= 1'b0;
      result_q       <= {CLASS_W{1'b0}};
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      pending_q      <= 1'b0;
      overrun_q      <= 1'b0;
      drop_cnt_q     <= {DROP_W{1'b0}};
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      l1_start_q     <= l1_start_d;
      l2_start_q     <= l2_start_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      pending_q      <= pending_d;
      overrun_q      <= overrun_d;
      drop_cnt_q     <= drop_cnt_d;
      error_q        <= error_d;
    end
  end

  assign l1_start     = l1_start_q;
  assign l2_start     = l2_start_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign pending      = pending_q;
  assign overrun      = overrun_q;
  assign drop_cnt     = drop_cnt_q;
  assign error        = error_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: directed scripts from the test plan plus
// random pulses, all compared each cycle against a transaction-level model of
// the sequencer (phase of the current inference, queued image, drop tally).
module tb_inference_sequencer;
  import inference_pkg::*;

  localparam int unsigned TMO = 16;
  localparam int unsigned DW  = 2;
`ifdef INFERENCE_SEQ_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               img_ready = 1'b0;
  logic               l1_done = 1'b0;
  logic               l2_done = 1'b0;
  logic [CLASS_W-1:0] l2_class = 4'd0;
  logic               l1_start, l2_start, result_valid, busy, pending, overrun, error;
  logic [CLASS_W-1:0] result;
  logic [DW-1:0]      drop_cnt;

  inference_sequencer #(.TIMEOUT_CYCLES(TMO), .DROP_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .img_ready(img_ready),
    .l1_start(l1_start), .l1_done(l1_done), .l2_start(l2_start),
    .l2_done(l2_done), .l2_class(l2_class), .result(result),
    .result_valid(result_valid), .busy(busy), .pending(pending),
    .overrun(overrun), .drop_cnt(drop_cnt), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 = no inference, 1 = Layer 1 running,
  // 2 = Layer 2 running, 3 = reporting the result.
  int       m_phase;
  bit       m_queued;
  int       m_drops;
  int       m_last;
  int       m_wait;
  bit       e_l1s, e_l2s, e_rv, e_ovr, e_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_queued = 0; m_drops = 0; m_last = 0; m_wait = 0;
    e_l1s = 0; e_l2s = 0; e_rv = 0; e_ovr = 0; e_err = 0;
  endtask

  task automatic model_step(input bit ir, input bit d1, input bit d2, input int cls);
    int  ph;
    bit  q;
    ph = m_phase;
    q  = m_queued;
    e_l1s = 0; e_l2s = 0; e_rv = 0; e_ovr = 0; e_err = 0;
    if (ph != 0 && ir) begin
      if (!q) m_queued = 1;
      else begin
        e_ovr = 1;
        if (m_drops < (1 << DW) - 1) m_drops++;
      end
    end
    case (ph)
      0: if (ir || q) begin m_phase = 1; m_queued = 0; e_l1s = 1; m_wait = 0; end
      1: begin
        if (d1) begin m_phase = 2; e_l2s = 1; m_wait = 0; end
        else if (WD_ON && m_wait == int'(TMO) - 1) begin m_phase = 0; e_err = 1; end
        else m_wait++;
      end
      2: begin
        if (d2) begin m_phase = 3; m_last = cls; e_rv = 1; end
        else if (WD_ON && m_wait == int'(TMO) - 1) begin m_phase = 0; e_err = 1; end
        else m_wait++;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    check("l1_start", l1_start, e_l1s);
    check("l2_start", l2_start, e_l2s);
    check("result_valid", result_valid, e_rv);
    check("result", result, m_last);
    check("busy", busy, m_phase != 0);
    check("pending", pending, m_queued);
    check("overrun", overrun, e_ovr);
    check("drop_cnt", drop_cnt, m_drops);
    check("error", error, e_err);
  endtask

  // One clock: check what the last edge produced, then drive the next inputs.
  task automatic drive_cycle(input bit ir, input bit d1, input bit d2, input int cls);
    @(negedge clk);
    check_outputs();
    img_ready = ir; l1_done = d1; l2_done = d2; l2_class = cls[3:0];
    model_step(ir, d1, d2, cls);
  endtask

  initial begin
    bit reached;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Test-plan run: start at 10, queue at 30, class 7 at 80; strays at 5, 20.
    for (int c = 0; c < 100; c++)
      drive_cycle(c == 10 || c == 30, c == 50 || c == 5, c == 80 || c == 20, 7);

    // Done pulses in the first cycle of each wait state.
    for (int c = 0; c < 10; c++)
      drive_cycle(c == 2, c == 3, c == 4, 12);

    // Six images during one run: one queued, five dropped -> counter saturates.
    for (int c = 0; c < 40; c++)
      drive_cycle(c == 2 || (c >= 4 && c <= 14 && c % 2 == 0), c == 12, c == 13, 3);

    // Random pulses, long enough to hit queueing, drops and strays.
    for (int c = 0; c < 2500; c++)
      drive_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));

    // Steer into Layer 2 with an image queued, then reset mid-run.
    reached = 0;
    for (int c = 0; c < 200 && !reached; c++) begin
      if (m_phase == 2 && m_queued) reached = 1;
      else drive_cycle(m_phase == 0 || !m_queued, m_phase == 1, 1'b0, 5);
    end
    check("reach_l2_pending", reached, 1'b1);
    @(posedge clk);
    #2;
    img_ready = 0; l1_done = 0; l2_done = 0;
    rst_n = 1'b0;
    #1;
    check("rst_l1_start", l1_start, 1'b0);
    check("rst_l2_start", l2_start, 1'b0);
    check("rst_result", result, 4'd0);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pending", pending, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_drop_cnt", drop_cnt, 2'd0);
    check("rst_error", error, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) drive_cycle(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
